cmd_sequencer: RTL

CMD_SEQUENCER -- requirements
Module: cmd_sequencer

---
 rtl/cmd_sequencer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/cmd_sequencer.sv
// Command sequencer: fetches 16-bit command words from a show-ahead FIFO and
// drives Bus Pirate IO pins (static levels, delays, mode-0 SPI byte transfers).
module cmd_sequencer #(
    parameter int BP_PINS    = 5,
    parameter int FIFO_WIDTH = 16,
    parameter int SPI_HALF   = 2,
    parameter int PIN_MOSI   = 0,
    parameter int PIN_CLK    = 1,
    parameter int PIN_MISO   = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pause,
    input  logic [FIFO_WIDTH-1:0] cmd_data,
    input  logic                  cmd_nempty,
    output logic                  cmd_pop,
    output logic [FIFO_WIDTH-1:0] res_data,
    input  logic                  res_full,
    output logic                  res_push,
    input  logic [BP_PINS-1:0]    io_in,
    output logic [BP_PINS-1:0]    io_out,
    output logic                  active,
    output logic                  bad_cmd,
    output logic [2:0]            dbg_state
);

    // Handshakes: cmd_pop is high for one cycle, only while cmd_nempty=1, and the
    // head word is consumed on that cycle's rising edge; res_push is high for one
    // cycle, only while res_full=0, and res_data is written on that edge.

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_EXEC    = 3'd1;
    localparam logic [2:0] S_DELAY   = 3'd2;
    localparam logic [2:0] S_SPI_SET = 3'd3;
    localparam logic [2:0] S_SPI_HI  = 3'd4;
    localparam logic [2:0] S_SPI_LO  = 3'd5;
    localparam logic [2:0] S_PUSH    = 3'd6;

    localparam logic [7:0] OP_SPI   = 8'h08;
    localparam logic [7:0] OP_PINS  = 8'h81;
    localparam logic [7:0] OP_DELAY = 8'h84;
    localparam logic [7:0] OP_LOW_A = 8'hFE;
    localparam logic [7:0] OP_LOW_B = 8'hFF;

    // SPI_LO already spends one low cycle, so later bits reload SET one shorter.
    localparam logic [7:0] HALF_LAST   = 8'(SPI_HALF - 1);
    localparam logic [7:0] HALF_RELOAD = (SPI_HALF > 1) ? 8'(SPI_HALF - 2) : 8'd0;

    logic [2:0]         state_q, state_d;
    logic [15:0]        cmd_q, cmd_d;
    logic [BP_PINS-1:0] io_q, io_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [7:0]         half_q, half_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic [7:0]         rx_q, rx_d;
    logic               bad_q, bad_d;

    logic [7:0] opcode;
    logic [7:0] arg;
    logic       fetch;
    logic       unused_io;

    assign opcode    = cmd_q[15:8];
    assign arg       = cmd_q[7:0];
    assign fetch     = (state_q == S_IDLE) && !pause && cmd_nempty;
    assign unused_io = ^io_in;

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        io_d     = io_q;
        cnt_d    = cnt_q;
        half_d   = half_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        rx_d     = rx_q;
        bad_d    = bad_q;
        res_push = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (fetch) begin
                    cmd_d   = cmd_data[15:0];
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                state_d = S_IDLE;
                case (opcode)
                    OP_PINS: io_d = arg[BP_PINS-1:0];
                    OP_LOW_A, OP_LOW_B: io_d = '0;
                    OP_DELAY: begin
                        if (arg != 8'd0) begin
                            cnt_d   = arg;
                            state_d = S_DELAY;
                        end
                    end
                    OP_SPI: begin
                        shift_d         = arg;
                        rx_d            = 8'd0;
                        bit_d           = 3'd7;
                        half_d          = HALF_LAST;
                        io_d[PIN_MOSI]  = arg[7];
                        io_d[PIN_CLK]   = 1'b0;
                        state_d         = S_SPI_SET;
                    end
                    default: bad_d = 1'b1;
                endcase
            end

            S_DELAY: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = S_IDLE;
                end
            end

            S_SPI_SET: begin
                if (half_q == 8'd0) begin
                    half_d        = HALF_LAST;
                    io_d[PIN_CLK] = 1'b1;
                    state_d       = S_SPI_HI;
                end else begin
                    half_d = half_q - 8'd1;
                end
            end

            S_SPI_HI: begin
                if (half_q == HALF_LAST) begin
                    rx_d = {rx_q[6:0], io_in[PIN_MISO]};
                end
                if (half_q == 8'd0) begin
                    io_d[PIN_CLK] = 1'b0;
                    // MOSI moves on the falling edge; the last bit stays on the pin.
                    if (bit_q != 3'd0) begin
                        io_d[PIN_MOSI] = shift_q[6];
                        shift_d        = {shift_q[6:0], 1'b0};
                    end
                    state_d = S_SPI_LO;
                end else begin
                    half_d = half_q - 8'd1;
                end
            end

            S_SPI_LO: begin
                if (bit_q == 3'd0) begin
                    state_d = S_PUSH;
                end else begin
                    bit_d = bit_q - 3'd1;
                    if (SPI_HALF == 1) begin
                        half_d        = HALF_LAST;
                        io_d[PIN_CLK] = 1'b1;
                        state_d       = S_SPI_HI;
                    end else begin
                        half_d  = HALF_RELOAD;
                        state_d = S_SPI_SET;
                    end
                end
            end

            S_PUSH: begin
                if (!res_full) begin
                    res_push = 1'b1;
                    state_d  = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cmd_q   <= 16'd0;
            io_q    <= '0;
            cnt_q   <= 8'd0;
            half_q  <= 8'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            rx_q    <= 8'd0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            io_q    <= io_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            rx_q    <= rx_d;
            bad_q   <= bad_d;
        end
    end

    // The pop is combinational from IDLE, so it must be masked while reset holds IDLE.
    assign cmd_pop   = fetch && !reset;
    assign res_data  = {{(FIFO_WIDTH-8){1'b0}}, rx_q};
    assign io_out    = io_q;
    assign active    = (state_q != S_IDLE);
    assign bad_cmd   = bad_q;
    assign dbg_state = state_q;

endmodule
